// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: funct3 access codes,
// size encodings, the access FSM states and the byte-mask helper.
package mem_pkg;

  localparam int MEM_XLEN = 64;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: request byte enables, store shift, access legality,
// and load shift + sign/zero extension. Zero latency, no flow control of its own.
module mem_lane_align #(
  parameter int XLEN = 64
) (
  input  logic            rd_en_i,
  input  logic            wr_en_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [2:0]      req_off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [7:0]      be_o,
  output logic [XLEN-1:0] st_data_o,
  output logic            err_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [2:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_raw_i,
  output logic [XLEN-1:0] ld_data_o
);
  import mem_pkg::*;

  logic            misaligned;
  logic            illegal;
  logic [XLEN-1:0] ld_sh;

  always_comb begin
    case (req_funct3_i[1:0])
      SZ_H:    misaligned = req_off_i[0];
      SZ_W:    misaligned = |req_off_i[1:0];
      SZ_D:    misaligned = |req_off_i;
      default: misaligned = 1'b0;
    endcase
  end

  // Unsigned encodings do not exist for stores, and 111 is unused for loads.
  assign illegal = (rd_en_i & wr_en_i)
                 | (rd_en_i & (req_funct3_i == F3_ILL))
                 | (wr_en_i & req_funct3_i[2]);
  assign err_o   = (rd_en_i | wr_en_i) & (misaligned | illegal);

  assign be_o      = size_mask(req_funct3_i[1:0]) << req_off_i;
  assign st_data_o = st_data_i << {req_off_i, 3'b000};
  assign ld_sh     = ld_raw_i >> {ld_off_i, 3'b000};

  always_comb begin
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ld_data_o = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      F3_W:    ld_data_o = {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      F3_D:    ld_data_o = ld_sh;
      F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
      F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
      F3_WU:   ld_data_o = {{(XLEN-32){1'b0}}, ld_sh[31:0]};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: turns load/store controls into a registered req/ack memory access, stalling
// upstream from the issue cycle until the ack (or timeout) cycle; result shown in DONE.
module mem_access_unit #(
  parameter int XLEN    = mem_pkg::MEM_XLEN,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ALU_result,
  input  logic [XLEN-1:0] WriteData,
  input  logic [4:0]      rd,
  input  logic            RegWrite,
  input  logic            MemtoReg,
  output logic            stall,
  output logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] ALU_result_out,
  output logic [4:0]      rd_out,
  output logic            RegWrite_out,
  output logic            MemtoReg_out,
  output logic            mem_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_be,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack
);
  import mem_pkg::*;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      be_q, be_d;
  logic [2:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            mem_op;
  logic            lane_err;
  logic [7:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_ld;
  logic            kill_wb;

  assign mem_op = in_valid & (MemRead | MemWrite);

  // Load extension uses the offset/size captured at issue, not the live inputs.
  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .rd_en_i      (MemRead),
    .wr_en_i      (MemWrite),
    .req_funct3_i (funct3),
    .req_off_i    (ALU_result[2:0]),
    .st_data_i    (WriteData),
    .be_o         (lane_be),
    .st_data_o    (lane_wdata),
    .err_o        (lane_err),
    .ld_funct3_i  (f3_q),
    .ld_off_i     (off_q),
    .ld_raw_i     (dmem_rdata),
    .ld_data_o    (lane_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    off_d    = off_q;
    f3_d     = f3_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    stall    = 1'b0;
    mem_err  = 1'b0;
    ReadData = '0;
    kill_wb  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (lane_err) begin
            mem_err = 1'b1;
            kill_wb = 1'b1;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {ALU_result[XLEN-1:3], 3'b000};
            wdata_d = lane_wdata;
            be_d    = lane_be;
            off_d   = ALU_result[2:0];
            f3_d    = funct3;
            rdata_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        // An ack on the final counted cycle still completes the access.
        if (dmem_ack) begin
          rdata_d = we_q ? '0 : lane_ld;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ReadData = rdata_q;
        if (err_q) begin
          mem_err = 1'b1;
          kill_wb = 1'b1;
        end
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ALU_result_out = ALU_result;
  assign rd_out         = rd;
  assign RegWrite_out   = RegWrite & ~kill_wb;
  assign MemtoReg_out   = MemtoReg & ~kill_wb;

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule
